// File: rtl/mem_arbiter_pkg.sv
// Shared types for the unified-memory arbiter: memory access parameters,
// the arbiter FSM state and the transaction owner.
package mem_arbiter_pkg;

    // Architectural register / bus word
    typedef logic [31:0] arch_reg;

    typedef enum logic [0:0] {
        MEM_OP_READ  = 1'b0,
        MEM_OP_WRITE = 1'b1
    } mem_op_t;

    typedef enum logic [1:0] {
        MEM_ACCESS_BYTE = 2'd0,
        MEM_ACCESS_HALF = 2'd1,
        MEM_ACCESS_WORD = 2'd2
    } mem_access_t;

    typedef struct packed {
        mem_op_t     op;
        mem_access_t access_size;
        logic        load_unsigned;
    } mem_params_t;

    // Instruction fetch is always an unsigned full-word read
    localparam mem_params_t FETCH_PARAMS = '{
        op:            MEM_OP_READ,
        access_size:   MEM_ACCESS_WORD,
        load_unsigned: 1'b1
    };

    // Value driven on the memory parameter bus when no request is presented
    localparam mem_params_t NULL_PARAMS = '{
        op:            MEM_OP_READ,
        access_size:   MEM_ACCESS_BYTE,
        load_unsigned: 1'b0
    };

    typedef enum logic [0:0] {
        ARB_IDLE = 1'b0,
        ARB_WAIT = 1'b1
    } arb_state_t;

    typedef enum logic [0:0] {
        OWNER_FETCH = 1'b0,
        OWNER_DATA  = 1'b1
    } arb_owner_t;

    // Map a "data selected" flag onto the owner encoding
    function automatic arb_owner_t owner_of(input logic data_sel);
        return data_sel ? OWNER_DATA : OWNER_FETCH;
    endfunction

endpackage

// File: rtl/mem_arbiter.sv
// Two-requester arbiter sharing a single memory port between instruction
// fetch and load/store. One transaction in flight at a time, data has
// priority, a starvation counter guarantees fetch progress and a response
// timeout aborts transactions against hung memory.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 64,
    parameter int STARVE_LIMIT   = 4
) (
    input  logic        clock,
    input  logic        reset,

    // Instruction fetch requester
    input  logic        if_req_valid,
    input  arch_reg     if_addr,
    output logic        if_req_ready,
    output logic        if_resp_valid,
    output logic        if_resp_err,

    // Load/store requester
    input  logic        d_req_valid,
    input  arch_reg     d_addr,
    input  arch_reg     d_wdata,
    input  mem_params_t d_params,
    output logic        d_req_ready,
    output logic        d_resp_valid,
    output logic        d_resp_err,

    // Shared response data
    output arch_reg     resp_rdata,

    // Memory port
    output logic        mem_req_valid,
    input  logic        mem_req_ready,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output mem_params_t mem_params,
    input  logic        mem_resp_valid,
    input  logic [31:0] mem_rdata,

    output logic        bus_error
);

    localparam int TO_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam int ST_W = $clog2(STARVE_LIMIT + 1);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);
    localparam logic [ST_W-1:0] ST_MAX  = ST_W'(STARVE_LIMIT);

    arb_state_t      state_reg, state_next;
    arb_owner_t      owner_reg, owner_next;
    logic [TO_W-1:0] timeout_cnt_reg, timeout_cnt_next;
    logic [ST_W-1:0] starve_cnt_reg, starve_cnt_next;
    logic            bus_error_reg, bus_error_next;
    // Selection latched while a presented request is stalled by memory
    logic            lock_valid_reg, lock_valid_next;
    arb_owner_t      lock_owner_reg, lock_owner_next;

    logic       fetch_priority;
    logic       any_valid;
    logic       lock_hold;
    logic       sel_data;
    arb_owner_t sel_owner;
    logic       accept;
    logic       resp_hit;
    logic       timeout_hit;
    logic       finish;

    // Combinational request selection and transaction events
    always_comb begin
        fetch_priority = if_req_valid && (starve_cnt_reg == ST_MAX);
        any_valid      = if_req_valid || d_req_valid;
        // A stalled choice stays put as long as that requester is still asking
        lock_hold      = lock_valid_reg &&
                         ((lock_owner_reg == OWNER_DATA) ? d_req_valid : if_req_valid);
        if (lock_hold) begin
            sel_data = (lock_owner_reg == OWNER_DATA);
        end else begin
            sel_data = d_req_valid && !fetch_priority;
        end
        sel_owner   = owner_of(sel_data);
        accept      = !reset && (state_reg == ARB_IDLE) && any_valid && mem_req_ready;
        resp_hit    = !reset && (state_reg == ARB_WAIT) && mem_resp_valid;
        timeout_hit = !reset && (state_reg == ARB_WAIT) && !mem_resp_valid &&
                      (timeout_cnt_reg == TO_LAST);
        finish      = resp_hit || timeout_hit;
    end

    // FSM state register
    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg <= ARB_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // FSM next-state logic
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ARB_IDLE: if (accept) state_next = ARB_WAIT;
            ARB_WAIT: if (finish) state_next = ARB_IDLE;
            default:  state_next = ARB_IDLE;
        endcase
    end

    // Next values for owner, timeout, starvation, lock and sticky error
    always_comb begin
        owner_next       = owner_reg;
        timeout_cnt_next = timeout_cnt_reg;
        starve_cnt_next  = starve_cnt_reg;
        bus_error_next   = bus_error_reg | timeout_hit;
        lock_valid_next  = 1'b0;
        lock_owner_next  = lock_owner_reg;

        case (state_reg)
            ARB_IDLE: begin
                if (accept) begin
                    owner_next       = sel_owner;
                    timeout_cnt_next = '0;
                end
                if (!if_req_valid) begin
                    starve_cnt_next = '0;
                end else if (accept && !sel_data) begin
                    starve_cnt_next = '0;
                end else if (sel_data && (starve_cnt_reg != ST_MAX)) begin
                    starve_cnt_next = starve_cnt_reg + ST_W'(1);
                end
                if (any_valid && !mem_req_ready) begin
                    lock_valid_next = 1'b1;
                    lock_owner_next = sel_owner;
                end
            end
            ARB_WAIT: begin
                if (finish) begin
                    timeout_cnt_next = '0;
                end else begin
                    timeout_cnt_next = timeout_cnt_reg + TO_W'(1);
                end
            end
            default: ;
        endcase
    end

    // Datapath registers
    always_ff @(posedge clock) begin
        if (reset) begin
            owner_reg       <= OWNER_FETCH;
            timeout_cnt_reg <= '0;
            starve_cnt_reg  <= '0;
            bus_error_reg   <= 1'b0;
            lock_valid_reg  <= 1'b0;
            lock_owner_reg  <= OWNER_FETCH;
        end else begin
            owner_reg       <= owner_next;
            timeout_cnt_reg <= timeout_cnt_next;
            starve_cnt_reg  <= starve_cnt_next;
            bus_error_reg   <= bus_error_next;
            lock_valid_reg  <= lock_valid_next;
            lock_owner_reg  <= lock_owner_next;
        end
    end

    // FSM outputs: request mux in IDLE, response routing in WAIT
    always_comb begin
        if_req_ready  = 1'b0;
        d_req_ready   = 1'b0;
        mem_req_valid = 1'b0;
        mem_addr      = '0;
        mem_wdata     = '0;
        mem_params    = NULL_PARAMS;
        if_resp_valid = 1'b0;
        if_resp_err   = 1'b0;
        d_resp_valid  = 1'b0;
        d_resp_err    = 1'b0;
        resp_rdata    = '0;

        if (!reset) begin
            case (state_reg)
                ARB_IDLE: begin
                    if (any_valid) begin
                        mem_req_valid = 1'b1;
                        if (sel_data) begin
                            d_req_ready = mem_req_ready;
                            mem_addr    = d_addr;
                            mem_wdata   = d_wdata;
                            mem_params  = d_params;
                        end else begin
                            if_req_ready = mem_req_ready;
                            mem_addr     = if_addr;
                            mem_params   = FETCH_PARAMS;
                        end
                    end
                end
                ARB_WAIT: begin
                    if (finish) begin
                        if (owner_reg == OWNER_DATA) begin
                            d_resp_valid = 1'b1;
                            d_resp_err   = timeout_hit;
                        end else begin
                            if_resp_valid = 1'b1;
                            if_resp_err   = timeout_hit;
                        end
                        // A timed-out transaction returns zero data
                        resp_rdata = resp_hit ? mem_rdata : '0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus_error = bus_error_reg;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: a table of single-cycle selection vectors
// followed by hand-written multi-cycle sequences.
module tb_mem_arbiter;
    import mem_arbiter_pkg::*;

    logic        clock = 1'b0;
    logic        reset;
    logic        if_req_valid;
    arch_reg     if_addr;
    logic        if_req_ready;
    logic        if_resp_valid;
    logic        if_resp_err;
    logic        d_req_valid;
    arch_reg     d_addr;
    arch_reg     d_wdata;
    mem_params_t d_params;
    logic        d_req_ready;
    logic        d_resp_valid;
    logic        d_resp_err;
    arch_reg     resp_rdata;
    logic        mem_req_valid;
    logic        mem_req_ready;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    mem_params_t mem_params;
    logic        mem_resp_valid;
    logic [31:0] mem_rdata;
    logic        bus_error;

    // Parameter encodings {op, access_size, load_unsigned}
    localparam logic [3:0] P_FETCH   = 4'h5;  // read, word, unsigned
    localparam logic [3:0] P_ST_WORD = 4'hC;  // write, word
    localparam logic [3:0] P_LD_WORD = 4'h4;  // read, word, signed

    mem_arbiter #(.TIMEOUT_CYCLES(64), .STARVE_LIMIT(4)) dut (
        .clock(clock), .reset(reset),
        .if_req_valid(if_req_valid), .if_addr(if_addr), .if_req_ready(if_req_ready),
        .if_resp_valid(if_resp_valid), .if_resp_err(if_resp_err),
        .d_req_valid(d_req_valid), .d_addr(d_addr), .d_wdata(d_wdata), .d_params(d_params),
        .d_req_ready(d_req_ready), .d_resp_valid(d_resp_valid), .d_resp_err(d_resp_err),
        .resp_rdata(resp_rdata),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_params(mem_params),
        .mem_resp_valid(mem_resp_valid), .mem_rdata(mem_rdata),
        .bus_error(bus_error)
    );

    always #5 clock = ~clock;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic        iv;
        logic [31:0] ia;
        logic        dv;
        logic [31:0] da;
        logic [31:0] dw;
        logic [3:0]  dp;
        logic        mr;
        logic        e_ir;
        logic        e_dr;
        logic        e_mv;
        logic [31:0] e_ma;
        logic [31:0] e_mw;
        logic [3:0]  e_mp;
    } vec_t;

    localparam int NVEC = 8;
    vec_t vecs[NVEC];

    task automatic chk1(input string name, input logic act, input logic exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %b want %b", name, act, exp);
        end
    endtask

    task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic settle();
        @(negedge clock);
    endtask

    task automatic clear_inputs();
        if_req_valid   = 1'b0;
        if_addr        = '0;
        d_req_valid    = 1'b0;
        d_addr         = '0;
        d_wdata        = '0;
        d_params       = mem_params_t'(4'h0);
        mem_req_ready  = 1'b0;
        mem_resp_valid = 1'b0;
        mem_rdata      = '0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        clear_inputs();
        step();
        step();
        reset = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        vecs[0] = '{1'b0, 32'h0,   1'b0, 32'h0,   32'h0,        4'h0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0,   32'h0,        4'h0};
        vecs[1] = '{1'b1, 32'h100, 1'b0, 32'h0,   32'h0,        4'h0, 1'b1, 1'b1, 1'b0, 1'b1, 32'h100, 32'h0,        4'h5};
        vecs[2] = '{1'b1, 32'h100, 1'b0, 32'h0,   32'h0,        4'h0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h100, 32'h0,        4'h5};
        vecs[3] = '{1'b0, 32'h0,   1'b1, 32'h200, 32'hDEADBEEF, 4'hC, 1'b1, 1'b0, 1'b1, 1'b1, 32'h200, 32'hDEADBEEF, 4'hC};
        vecs[4] = '{1'b1, 32'h108, 1'b1, 32'h204, 32'h1234,     4'h1, 1'b1, 1'b0, 1'b1, 1'b1, 32'h204, 32'h1234,     4'h1};
        vecs[5] = '{1'b1, 32'h108, 1'b1, 32'h204, 32'h1234,     4'h1, 1'b0, 1'b0, 1'b0, 1'b1, 32'h204, 32'h1234,     4'h1};
        vecs[6] = '{1'b1, 32'h10C, 1'b0, 32'h999, 32'hFFFFFFFF, 4'hC, 1'b1, 1'b1, 1'b0, 1'b1, 32'h10C, 32'h0,        4'h5};
        vecs[7] = '{1'b0, 32'h0,   1'b1, 32'h20C, 32'h5A5A,     4'hA, 1'b1, 1'b0, 1'b1, 1'b1, 32'h20C, 32'h5A5A,     4'hA};

        // Outputs held at zero while reset is asserted, even with requests present
        clear_inputs();
        reset = 1'b1;
        if_req_valid = 1'b1; if_addr = 32'h40; d_req_valid = 1'b1; d_addr = 32'h80;
        mem_req_ready = 1'b1; mem_resp_valid = 1'b1; mem_rdata = 32'h1111;
        settle();
        chk1("rst_if_ready", if_req_ready, 1'b0);
        chk1("rst_d_ready", d_req_ready, 1'b0);
        chk1("rst_mem_valid", mem_req_valid, 1'b0);
        chk1("rst_if_resp", if_resp_valid, 1'b0);
        chk1("rst_d_resp", d_resp_valid, 1'b0);
        chk32("rst_mem_addr", mem_addr, 32'h0);
        step();
        step();
        settle();
        chk1("rst_bus_error", bus_error, 1'b0);
        $display("txn reset check");

        // Table-driven selection vectors, each from a fresh IDLE
        for (int i = 0; i < NVEC; i++) begin
            do_reset();
            if_req_valid  = vecs[i].iv;
            if_addr       = vecs[i].ia;
            d_req_valid   = vecs[i].dv;
            d_addr        = vecs[i].da;
            d_wdata       = vecs[i].dw;
            d_params      = mem_params_t'(vecs[i].dp);
            mem_req_ready = vecs[i].mr;
            settle();
            chk1($sformatf("vec%0d_if_ready", i), if_req_ready, vecs[i].e_ir);
            chk1($sformatf("vec%0d_d_ready", i), d_req_ready, vecs[i].e_dr);
            chk1($sformatf("vec%0d_mem_valid", i), mem_req_valid, vecs[i].e_mv);
            chk32($sformatf("vec%0d_mem_addr", i), mem_addr, vecs[i].e_ma);
            chk32($sformatf("vec%0d_mem_wdata", i), mem_wdata, vecs[i].e_mw);
            chk32($sformatf("vec%0d_mem_params", i), 32'(mem_params), 32'(vecs[i].e_mp));
            $display("txn vec %0d addr=%h params=%h", i, mem_addr, mem_params);
            step();
            clear_inputs();
        end

        // Fetch only, memory answers on the third WAIT cycle
        do_reset();
        if_req_valid = 1'b1; if_addr = 32'h100; mem_req_ready = 1'b1;
        settle();
        chk1("t1_if_ready", if_req_ready, 1'b1);
        chk32("t1_params", 32'(mem_params), 32'(P_FETCH));
        step();
        if_req_valid = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            if (k == 3) begin
                mem_resp_valid = 1'b1;
                mem_rdata = 32'h00000013;
            end
            settle();
            chk1("t1_wait_ready", if_req_ready, 1'b0);
            chk1("t1_wait_memvalid", mem_req_valid, 1'b0);
            chk1("t1_if_resp", if_resp_valid, k == 3);
            if (k == 3) chk32("t1_rdata", resp_rdata, 32'h13);
            step();
        end
        mem_resp_valid = 1'b0;
        settle();
        chk1("t1_resp_pulse_end", if_resp_valid, 1'b0);
        $display("txn t1 fetch 0x100 done");

        // Both valid: data store first, fetch in the next IDLE
        do_reset();
        if_req_valid = 1'b1; if_addr = 32'h104;
        d_req_valid = 1'b1; d_addr = 32'h200; d_wdata = 32'hDEADBEEF;
        d_params = mem_params_t'(P_ST_WORD); mem_req_ready = 1'b1;
        settle();
        chk1("t2_d_ready", d_req_ready, 1'b1);
        chk1("t2_if_ready", if_req_ready, 1'b0);
        chk32("t2_wdata", mem_wdata, 32'hDEADBEEF);
        step();
        d_req_valid = 1'b0;
        mem_resp_valid = 1'b1;
        settle();
        chk1("t2_d_resp", d_resp_valid, 1'b1);
        chk1("t2_if_resp_early", if_resp_valid, 1'b0);
        chk1("t2_no_accept_on_resp", if_req_ready, 1'b0);
        step();
        mem_resp_valid = 1'b0;
        settle();
        chk1("t2_if_ready_next", if_req_ready, 1'b1);
        chk32("t2_if_addr", mem_addr, 32'h104);
        step();
        if_req_valid = 1'b0;
        mem_resp_valid = 1'b1; mem_rdata = 32'h00C0FFEE;
        settle();
        chk1("t2_if_resp", if_resp_valid, 1'b1);
        chk32("t2_if_rdata", resp_rdata, 32'h00C0FFEE);
        step();
        mem_resp_valid = 1'b0;
        $display("txn t2 store then fetch");

        // Starvation: fetch wins after four data grants, then counter restarts
        do_reset();
        d_req_valid = 1'b1; d_addr = 32'h700; d_params = mem_params_t'(P_LD_WORD);
        if_req_valid = 1'b1; if_addr = 32'h800;
        mem_req_ready = 1'b1; mem_resp_valid = 1'b1; mem_rdata = 32'h55;
        for (int i = 0; i < 10; i++) begin
            logic exp_f;
            exp_f = ((i % 5) == 4);
            settle();
            chk1($sformatf("t3_if_grant%0d", i), if_req_ready, exp_f);
            chk1($sformatf("t3_d_grant%0d", i), d_req_ready, !exp_f);
            step();
            settle();
            chk1($sformatf("t3_if_resp%0d", i), if_resp_valid, exp_f);
            chk1($sformatf("t3_d_resp%0d", i), d_resp_valid, !exp_f);
            step();
            $display("txn t3 grant %0d to %s", i, exp_f ? "fetch" : "data");
        end
        clear_inputs();

        // Memory stall: selection and address stay fixed until accepted
        do_reset();
        d_req_valid = 1'b1; d_addr = 32'h300; d_params = mem_params_t'(P_LD_WORD);
        if_req_valid = 1'b1; if_addr = 32'h900; mem_req_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            settle();
            chk1("t4_stall_d_ready", d_req_ready, 1'b0);
            chk1("t4_stall_if_ready", if_req_ready, 1'b0);
            chk1("t4_stall_valid", mem_req_valid, 1'b1);
            chk32("t4_stall_addr", mem_addr, 32'h300);
            step();
        end
        mem_req_ready = 1'b1;
        settle();
        chk1("t4_accept_d", d_req_ready, 1'b1);
        chk32("t4_accept_addr", mem_addr, 32'h300);
        step();
        mem_resp_valid = 1'b1;
        settle();
        chk1("t4_d_resp", d_resp_valid, 1'b1);
        step();
        mem_resp_valid = 1'b0;
        settle();
        chk1("t4_fetch_priority", if_req_ready, 1'b1);
        chk32("t4_fetch_addr", mem_addr, 32'h900);
        step();
        clear_inputs();
        $display("txn t4 stalled data then fetch");

        // Response in the last WAIT cycle beats the timeout
        do_reset();
        d_req_valid = 1'b1; d_addr = 32'h400; d_params = mem_params_t'(P_LD_WORD);
        mem_req_ready = 1'b1;
        settle();
        chk1("t5a_d_ready", d_req_ready, 1'b1);
        step();
        d_req_valid = 1'b0;
        for (int k = 1; k <= 64; k++) begin
            if (k == 64) begin
                mem_resp_valid = 1'b1;
                mem_rdata = 32'hCAFE0001;
            end
            settle();
            if (k == 63) chk1("t5a_resp63", d_resp_valid, 1'b0);
            if (k == 64) begin
                chk1("t5a_resp64", d_resp_valid, 1'b1);
                chk1("t5a_err64", d_resp_err, 1'b0);
                chk32("t5a_rdata64", resp_rdata, 32'hCAFE0001);
            end
            step();
        end
        mem_resp_valid = 1'b0;
        settle();
        chk1("t5a_bus_error", bus_error, 1'b0);
        $display("txn t5a late response wins over timeout");

        // Timeout: error response in WAIT cycle 64, sticky bus_error, stray response ignored
        do_reset();
        d_req_valid = 1'b1; d_addr = 32'h404; d_params = mem_params_t'(P_LD_WORD);
        mem_req_ready = 1'b1; mem_rdata = 32'hAAAA5555;
        settle();
        chk1("t5_d_ready", d_req_ready, 1'b1);
        step();
        d_req_valid = 1'b0;
        for (int k = 1; k <= 64; k++) begin
            settle();
            chk1($sformatf("t5_resp%0d", k), d_resp_valid, k == 64);
            if (k == 64) begin
                chk1("t5_err", d_resp_err, 1'b1);
                chk32("t5_rdata", resp_rdata, 32'h0);
                chk1("t5_if_resp", if_resp_valid, 1'b0);
            end
            step();
        end
        for (int k = 65; k <= 70; k++) begin
            if (k == 70) mem_resp_valid = 1'b1;
            settle();
            chk1($sformatf("t5_bus_error%0d", k), bus_error, 1'b1);
            chk1($sformatf("t5_stray_d%0d", k), d_resp_valid, 1'b0);
            chk1($sformatf("t5_stray_if%0d", k), if_resp_valid, 1'b0);
            step();
        end
        mem_resp_valid = 1'b0;
        $display("txn t5 timeout err bus_error=%b", bus_error);

        // Reset during WAIT discards the transaction; later fetch completes
        do_reset();
        chk1("t6_bus_error_cleared", bus_error, 1'b0);
        if_req_valid = 1'b1; if_addr = 32'h500; mem_req_ready = 1'b1;
        settle();
        chk1("t6_if_ready", if_req_ready, 1'b1);
        step();
        if_req_valid = 1'b0;
        reset = 1'b1;
        settle();
        chk1("t6_rst_if_resp", if_resp_valid, 1'b0);
        chk1("t6_rst_mem_valid", mem_req_valid, 1'b0);
        step();
        reset = 1'b0;
        mem_resp_valid = 1'b1; mem_rdata = 32'h77;
        settle();
        chk1("t6_late_if_resp", if_resp_valid, 1'b0);
        chk1("t6_late_d_resp", d_resp_valid, 1'b0);
        chk1("t6_mem_valid", mem_req_valid, 1'b0);
        chk32("t6_rdata", resp_rdata, 32'h0);
        chk1("t6_bus_error", bus_error, 1'b0);
        step();
        mem_resp_valid = 1'b0;
        if_req_valid = 1'b1; if_addr = 32'h600;
        settle();
        chk1("t6_new_if_ready", if_req_ready, 1'b1);
        chk32("t6_new_addr", mem_addr, 32'h600);
        step();
        if_req_valid = 1'b0;
        mem_resp_valid = 1'b1; mem_rdata = 32'h600D;
        settle();
        chk1("t6_new_if_resp", if_resp_valid, 1'b1);
        chk32("t6_new_rdata", resp_rdata, 32'h600D);
        step();
        clear_inputs();
        $display("txn t6 reset in WAIT then fetch 0x600");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
Shares one memory port between the instruction-fetch requester and the load/store requester. This lets the core run on a single unified memory instead of separate imem/dmem instances.
- Accepts at most one transaction at a time.
- Uses a valid/ready request handshake and a response valid pulse.
- Routes each response back to the requester that issued it.
- Data has priority; a starvation counter guarantees fetch progress.
- A response timeout flags hung memory.

Parameters:
TIMEOUT_CYCLES, 64, WAIT cycles without mem_resp_valid before the transaction is aborted with an error.
STARVE_LIMIT, 4, consecutive denied fetch cycles after which fetch wins the next arbitration.

Ports:
clock  input  1  system clock
reset  input  1  synchronous, active-high reset
if_req_valid  input  1  fetch requests a word read
if_addr  input  32 (arch_reg)  fetch address
if_req_ready  output  1  fetch request accepted this cycle
if_resp_valid  output  1  fetch response pulse
if_resp_err  output  1  fetch response is a timeout error
d_req_valid  input  1  load/store request
d_addr  input  32 (arch_reg)  data address
d_wdata  input  32 (arch_reg)  store data
d_params  input  mem_params_t  op/access_size/load_unsigned
d_req_ready  output  1  data request accepted this cycle
d_resp_valid  output  1  data response pulse (loads and stores)
d_resp_err  output  1  data response is a timeout error
resp_rdata  output  32 (arch_reg)  read data, shared by both requesters, qualified by *_resp_valid
mem_req_valid  output  1  request to memory
mem_req_ready  input  1  memory accepts the request
mem_addr  output  32  memory address
mem_wdata  output  32  memory write data
mem_params  output  mem_params_t  memory access parameters
mem_resp_valid  input  1  memory response/ack pulse
mem_rdata  input  32  memory read data
bus_error  output  1  sticky; set on any timeout

Behaviour:
Reset values: state IDLE; timeout counter 0; starve counter 0; bus_error 0. All valid/ready outputs are 0 during reset.

Clock and reset:
- One clock.
- reset is synchronous and active-high. It returns the block to IDLE from any state and discards the outstanding transaction.
- A mem_resp_valid arriving after reset is ignored.

States:
- IDLE: no transaction outstanding.
- WAIT: one transaction outstanding; the owner register (FETCH/DATA) is valid.

IDLE, selection:
- Selection is combinational. Data wins if d_req_valid, unless fetch_priority is set. fetch_priority = if_req_valid and starve_cnt == STARVE_LIMIT.
- mem_req_valid = any request valid.
- The mem_addr/mem_wdata/mem_params mux follows the selected requester.
- A fetch request is always driven as load_unsigned=1, MEM_ACCESS_WORD, MEM_OP_READ; mem_wdata = 0.

IDLE, acceptance:
- The selected requester's req_ready = mem_req_ready. The other requester's req_ready = 0.
- On acceptance (selected valid and mem_req_ready): latch owner, clear the timeout counter, go to WAIT.

WAIT:
- All req_ready = 0 and mem_req_valid = 0.
- The counter increments each cycle.
- If mem_resp_valid: owner's resp_valid = 1 for one cycle, resp_rdata = mem_rdata, go to IDLE.
- Stores also complete on mem_resp_valid; the rdata is don't-care.

Timeout:
- Triggered when the counter reaches TIMEOUT_CYCLES-1 with no response.
- Owner's resp_valid = 1 and resp_err = 1 for one cycle, resp_rdata = 0.
- bus_error is set and held until reset. Go to IDLE.

Simultaneous response and timeout: the response wins; no error.

Responses in IDLE: a mem_resp_valid arriving in IDLE (late or stray) is ignored.

Throughput:
- Minimum 2 cycles per transaction.
- A new request is never accepted in the same cycle a response is returned.

Starvation counter:
- Increments (saturating at STARVE_LIMIT) each IDLE cycle in which if_req_valid=1 and data was selected.
- Clears when fetch is accepted or when if_req_valid=0.
- Holds during WAIT.

Request stability: requesters hold valid and payload stable until ready. The arbiter never changes its selection while mem_req_valid=1 and mem_req_ready=0, so the choice is latched across stall cycles.

Decomposition:
Package mem_arbiter_pkg holds:
- arb_state_t {ARB_IDLE, ARB_WAIT}
- arb_owner_t {OWNER_FETCH, OWNER_DATA}

mem_params_t, arch_reg and the MEM_* constants are reused from the existing packages. No sub-module; the selection mux and FSM are a single module.

Test Plan:
1. Fetch only, addr 0x100, memory responds 3 cycles after accept with 0x00000013 -> if_req_ready once, if_resp_valid one cycle with resp_rdata 0x13; mem_params is word/read/unsigned.
2. Both valid in the same IDLE cycle, d_params store word, d_wdata 0xDEADBEEF @0x200 -> data accepted first (mem_wdata 0xDEADBEEF); fetch is accepted in the next IDLE; d_resp_valid precedes if_resp_valid.
3. Data held valid continuously with fetch valid, 1-cycle memory -> fetch is granted after exactly STARVE_LIMIT=4 denials; starve_cnt returns to 0.
4. mem_req_ready low 5 cycles while both requesters are valid -> no ready, selection stable, mem_addr constant until accept.
5. No mem_resp_valid for 64 cycles after a data load -> d_resp_valid=1 with d_resp_err=1 in cycle 64; bus_error stays 1; a late mem_resp_valid in cycle 70 is ignored.
6. reset asserted in WAIT, memory responds the next cycle -> no resp_valid pulses, state IDLE, all outputs 0; a fetch issued after reset completes normally.
